// File: rtl/alu_pkg.sv
// Shared constants for the MIPS execute stage: ALU operation codes, ALUOp
// encodings from main control and the R-type funct values.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_INV = 4'b1111;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_IMM    = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;

endpackage

// File: rtl/alu_ctrl_dec.sv
// ALU control decoder: maps main-control ALUOp plus the R-type funct field
// onto a 4-bit ALU operation code.
module alu_ctrl_dec
  import alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_ctrl
);

  always_comb begin
    alu_ctrl = ALU_INV;
    case (alu_op)
      ALUOP_MEM:    alu_ctrl = ALU_ADD;
      ALUOP_BRANCH: alu_ctrl = ALU_SUB;
      ALUOP_IMM:    alu_ctrl = ALU_ADD;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD: alu_ctrl = ALU_ADD;
          FUNCT_SUB: alu_ctrl = ALU_SUB;
          FUNCT_AND: alu_ctrl = ALU_AND;
          FUNCT_OR:  alu_ctrl = ALU_OR;
          FUNCT_SLT: alu_ctrl = ALU_SLT;
          FUNCT_NOR: alu_ctrl = ALU_NOR;
          default:   alu_ctrl = ALU_INV;
        endcase
      end
      default: alu_ctrl = ALU_INV;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// MIPS execute stage: ALU control decode, 32-bit ALU with zero flag,
// PC-relative branch adder and the EX/MEM result register.
module alu_exec_unit
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [1:0]  alu_op,
  input  logic [5:0]  funct,
  input  logic [31:0] alu_in1,
  input  logic [31:0] alu_in2,
  input  logic [31:0] ra,
  input  logic [31:0] imd_add,
  output logic [3:0]  alu_ctrl,
  output logic [31:0] result,
  output logic        zero,
  output logic [31:0] branch_target,
  output logic [31:0] result_q,
  output logic        zero_q
);

  logic signed [31:0] a_s;
  logic signed [31:0] b_s;
  logic        [31:0] branch_offset;
  logic        [31:0] result_p1;
  logic               zero_p1;

  alu_ctrl_dec u_dec (
    .alu_op   (alu_op),
    .funct    (funct),
    .alu_ctrl (alu_ctrl)
  );

  assign a_s = alu_in1;
  assign b_s = alu_in2;

  always_comb begin
    result = 32'h0;
    case (alu_ctrl)
      ALU_AND: result = alu_in1 & alu_in2;
      ALU_OR:  result = alu_in1 | alu_in2;
      ALU_ADD: result = alu_in1 + alu_in2;
      ALU_SUB: result = alu_in1 - alu_in2;
      ALU_SLT: result = (a_s < b_s) ? 32'd1 : 32'd0;
      ALU_NOR: result = ~(alu_in1 | alu_in2);
      default: result = 32'h0;
    endcase
  end

  assign zero = (result == 32'h0);

  // Word offset: the shift drops imd_add[31:30], wrapping modulo 2^32.
  assign branch_offset = imd_add << 2;
  assign branch_target = ra + branch_offset;

  // EX/MEM boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_p1 <= 32'h0;
      zero_p1   <= 1'b0;
    end else if (!stall) begin
      result_p1 <= result;
      zero_p1   <= zero;
    end
  end

  assign result_q = result_p1;
  assign zero_q   = zero_p1;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed vector table, register
// control sequences and randomized traffic against a behavioural model.
module tb_alu_exec_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [31:0] ra;
  logic [31:0] imd_add;
  logic [3:0]  alu_ctrl;
  logic [31:0] result;
  logic        zero;
  logic [31:0] branch_target;
  logic [31:0] result_q;
  logic        zero_q;

  int checks = 0;
  int fails  = 0;

  alu_exec_unit dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .alu_op        (alu_op),
    .funct         (funct),
    .alu_in1       (alu_in1),
    .alu_in2       (alu_in2),
    .ra            (ra),
    .imd_add       (imd_add),
    .alu_ctrl      (alu_ctrl),
    .result        (result),
    .zero          (zero),
    .branch_target (branch_target),
    .result_q      (result_q),
    .zero_q        (zero_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ra;
    logic [31:0] imd;
    logic [3:0]  ctrl;
    logic [31:0] res;
    logic        z;
    logic [31:0] bt;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: name the operation first, then derive its code and value.
  typedef enum int {K_ADD, K_SUB, K_AND, K_OR, K_SLT, K_NOR, K_INV} kind_t;

  function automatic kind_t ref_kind(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'b00 || op == 2'b11) return K_ADD;
    if (op == 2'b01) return K_SUB;
    if (f == 6'd32) return K_ADD;
    if (f == 6'd34) return K_SUB;
    if (f == 6'd36) return K_AND;
    if (f == 6'd37) return K_OR;
    if (f == 6'd42) return K_SLT;
    if (f == 6'd39) return K_NOR;
    return K_INV;
  endfunction

  function automatic logic [3:0] ref_ctrl(input kind_t k);
    case (k)
      K_ADD: return 4'd2;
      K_SUB: return 4'd6;
      K_AND: return 4'd0;
      K_OR:  return 4'd1;
      K_SLT: return 4'd7;
      K_NOR: return 4'd12;
      default: return 4'd15;
    endcase
  endfunction

  function automatic logic [31:0] ref_res(input kind_t k, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    sa = $signed(a);
    sb = $signed(b);
    case (k)
      K_ADD: return 32'((longint'(a) + longint'(b)) % 64'h1_0000_0000);
      K_SUB: return 32'((longint'(a) - longint'(b) + 64'h1_0000_0000) % 64'h1_0000_0000);
      K_AND: return a & b;
      K_OR:  return a | b;
      K_SLT: return (sa < sb) ? 32'd1 : 32'd0;
      K_NOR: return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_bt(input logic [31:0] r, input logic [31:0] imd);
    longint t;
    t = longint'(r) + longint'($signed(imd)) * 4;
    return 32'(t);
  endfunction

  task automatic apply(input logic [1:0] op, input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] r, input logic [31:0] imd);
    alu_op = op; funct = f; alu_in1 = a; alu_in2 = b; ra = r; imd_add = imd;
  endtask

  initial begin
    vecs[0]  = '{2'b10, 6'b100000, 32'h7FFFFFFF, 32'h1,        32'h0,   32'h0,        4'b0010, 32'h80000000, 1'b0, 32'h0};
    vecs[1]  = '{2'b01, 6'b000000, 32'h1234,     32'h1234,     32'h0,   32'h0,        4'b0110, 32'h0,        1'b1, 32'h0};
    vecs[2]  = '{2'b01, 6'b000000, 32'h5,        32'h3,        32'h0,   32'h0,        4'b0110, 32'h2,        1'b0, 32'h0};
    vecs[3]  = '{2'b10, 6'b101010, 32'hFFFFFFFF, 32'h1,        32'h0,   32'h0,        4'b0111, 32'h1,        1'b0, 32'h0};
    vecs[4]  = '{2'b10, 6'b101010, 32'h1,        32'hFFFFFFFF, 32'h0,   32'h0,        4'b0111, 32'h0,        1'b1, 32'h0};
    vecs[5]  = '{2'b10, 6'b100100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0,   32'h0,        4'b0000, 32'hF000F000, 1'b0, 32'h0};
    vecs[6]  = '{2'b10, 6'b100101, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0,   32'h0,        4'b0001, 32'hFFF0FFF0, 1'b0, 32'h0};
    vecs[7]  = '{2'b10, 6'b100111, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0,   32'h0,        4'b1100, 32'h000F000F, 1'b0, 32'h0};
    vecs[8]  = '{2'b10, 6'b000000, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0,   32'h0,        4'b1111, 32'h0,        1'b1, 32'h0};
    vecs[9]  = '{2'b00, 6'b111111, 32'h100,      32'h24,       32'h104, 32'h3,        4'b0010, 32'h124,      1'b0, 32'h110};
    vecs[10] = '{2'b11, 6'b101010, 32'h1,        32'hFFFFFFFF, 32'h104, 32'hFFFFFFFF, 4'b0010, 32'h0,        1'b1, 32'h100};
    vecs[11] = '{2'b10, 6'b100010, 32'h3,        32'h5,        32'h0,   32'h80000000, 4'b0110, 32'hFFFFFFFE, 1'b0, 32'h0};

    rst = 1'b1; stall = 1'b0;
    apply(2'b00, 6'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_result_q", result_q, 32'h0);
    check("reset_zero_q", {31'd0, zero_q}, 32'h0);
    check("reset_comb_zero", {31'd0, zero}, 32'h1);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      apply(vecs[i].op, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].ra, vecs[i].imd);
      #2;
      check($sformatf("vec%0d_ctrl", i), {28'd0, alu_ctrl}, {28'd0, vecs[i].ctrl});
      check($sformatf("vec%0d_result", i), result, vecs[i].res);
      check($sformatf("vec%0d_zero", i), {31'd0, zero}, {31'd0, vecs[i].z});
      check($sformatf("vec%0d_bt", i), branch_target, vecs[i].bt);
    end

    // Latency and stall hold.
    @(posedge clk);
    #1;
    apply(2'b10, 6'b100000, 32'd2, 32'd3, 32'd0, 32'd0);
    #2;
    check("pre_edge_result_q", result_q, 32'hFFFFFFFE);
    @(posedge clk);
    #1;
    check("load_result_q", result_q, 32'd5);
    check("load_zero_q", {31'd0, zero_q}, 32'h0);
    stall = 1'b1;
    apply(2'b10, 6'b100000, 32'd0, 32'd0, 32'd0, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("stall%0d_result_q", i), result_q, 32'd5);
      check($sformatf("stall%0d_zero_q", i), {31'd0, zero_q}, 32'h0);
      apply(2'b01, 6'd0, 32'd7 + i, 32'd7 + i, 32'd0, 32'd0);
    end
    stall = 1'b0;
    @(posedge clk);
    #1;
    check("unstall_result_q", result_q, 32'h0);
    check("unstall_zero_q", {31'd0, zero_q}, 32'h1);

    // Mid-cycle asynchronous reset, then reset beats stall.
    apply(2'b10, 6'b100000, 32'd2, 32'd3, 32'd0, 32'd0);
    @(posedge clk);
    #1;
    check("reload_result_q", result_q, 32'd5);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_result_q", result_q, 32'h0);
    check("async_rst_zero_q", {31'd0, zero_q}, 32'h0);
    check("async_rst_comb", result, 32'd5);
    stall = 1'b1;
    @(posedge clk);
    #1;
    check("rst_stall_result_q", result_q, 32'h0);
    rst = 1'b0; stall = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_result_q", result_q, 32'd5);

    // Randomized traffic with a tracked register model.
    begin
      logic [31:0] exp_q;
      logic        exp_zq;
      logic [5:0]  fl[7];
      kind_t       k;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] er;
      fl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111, 6'b000000};
      exp_q = 32'd5; exp_zq = 1'b0;
      for (int i = 0; i < 300; i++) begin
        a = $urandom;
        b = ($urandom_range(0, 4) == 0) ? a : 32'($urandom);
        apply(2'($urandom_range(0, 3)),
              ($urandom_range(0, 5) == 0) ? 6'($urandom) : fl[$urandom_range(0, 6)],
              a, b, $urandom, $urandom);
        stall = ($urandom_range(0, 3) == 0);
        #2;
        k  = ref_kind(alu_op, funct);
        er = ref_res(k, a, b);
        check("rnd_ctrl", {28'd0, alu_ctrl}, {28'd0, ref_ctrl(k)});
        check("rnd_result", result, er);
        check("rnd_zero", {31'd0, zero}, {31'd0, er == 32'd0});
        check("rnd_bt", branch_target, ref_bt(ra, imd_add));
        if (!stall) begin
          exp_q = er;
          exp_zq = (er == 32'd0);
        end
        @(posedge clk);
        #1;
        check("rnd_result_q", result_q, exp_q);
        check("rnd_zero_q", {31'd0, zero_q}, {31'd0, exp_zq});
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
